// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, reads the instruction memory and
// holds one fetched word for decode behind a valid/ready handshake.
module fetch_sequencer #(
   parameter int ADDR_W    = 8,
   parameter int LAST_ADDR = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic              advance;
   logic              redir;
   logic              at_last;

   assign imem_addr = pc;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   // redirect only means something while a program is in flight
   assign redir     = redirect_valid & busy;
   assign advance   = (state == RUN) & (~out_valid | out_ready);
   assign at_last   = (pc == LAST);

   // sequencing state and PC; redirect overrides everything else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
      end else if (redir) begin
         state <= RUN;
         pc    <= redirect_pc;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  pc    <= '0;
               end
            end
            RUN: begin
               if (advance) begin
                  if (at_last) state <= DRAIN;
                  else         pc    <= pc + ONE;
               end
            end
            DRAIN: begin
               if (!out_valid || out_ready) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // one-entry output stage: flush on redirect, capture on advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else if (redir) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= 1'b1;
         out_instr <= imem_rd;
         out_pc    <= pc;
      end else if (state == DRAIN && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table of scenarios, reset corner cases
// and randomized handshake/redirect traffic against a stream model.
module tb_fetch_sequencer;

   localparam int LAST = 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        busy;
   logic        done;

   logic [31:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   fetch_sequencer #(.ADDR_W(8), .LAST_ADDR(LAST)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .done           (done)
   );

   assign imem_rd = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic       start;
      logic       ready;
      logic       rv;
      logic [7:0] rpc;
      logic       ev;
      logic [7:0] epc;
      logic [7:0] eaddr;
      logic       edone;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input bit ok, input string name,
                        input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(logic s, logic r, logic rv, logic [7:0] rpc,
                               logic ev, logic [7:0] epc, logic [7:0] ea,
                               logic ed);
      vec_t v;
      v.start = s; v.ready = r; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.eaddr = ea; v.edone = ed;
      vecs.push_back(v);
   endfunction

   function automatic logic [7:0] nxt(int k);
      return (k < LAST) ? 8'(k + 1) : 8'(LAST);
   endfunction

   function automatic void add_start();
      add(1, 1, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic void row_pc(int k, logic r);
      add(0, r, 0, 0, 1, 8'(k), nxt(k), 0);
   endfunction

   function automatic void add_tail(int from);
      for (int k = from; k <= LAST; k++) row_pc(k, 1);
      add(0, 1, 0, 0, 0, 0, 8'(LAST), 1);
   endfunction

   task automatic wait_neg(int n);
      repeat (n) @(negedge clk);
   endtask

   // one handshake-level expectation: valid word with given pc
   task automatic expect_word(input string name, input int k);
      logic [63:0] act, exp;
      act = {23'b0, out_valid, out_pc, out_instr};
      exp = {23'b0, 1'b1, 8'(k), mem[k]};
      check(act == exp, name, act, exp);
   endtask

   // random traffic: stream model of the accepted instruction sequence
   task automatic rand_run(input int id);
      int  exp_next;
      bit  active, flushed, finished, must_hold;
      int  nred;
      bit  do_red;
      start          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = 1'($urandom_range(0, 1));
      active   = 1;
      exp_next = 0;
      flushed  = 1;
      finished = 0;
      must_hold = 0;
      nred     = 0;
      for (int cyc = 0; cyc < 400 && active; cyc++) begin
         @(negedge clk);
         if (finished) begin
            check(done && !out_valid && !busy, "rand_done",
                  {61'b0, done, out_valid, busy}, 64'b100);
            active = 0;
            start = 1'b0;
            redirect_valid = 1'b0;
         end else begin
            check(busy && !done, "rand_busy", {62'b0, busy, done}, 64'b10);
            if (flushed)
               check(!out_valid, "rand_flush", 64'(out_valid), 64'd0);
            if (must_hold)
               check(out_valid, "rand_hold", 64'(out_valid), 64'd1);
            if (out_valid)
               check(out_pc == 8'(exp_next) && out_instr == mem[exp_next],
                     "rand_word", {24'b0, out_pc, out_instr},
                     {24'b0, 8'(exp_next), mem[exp_next]});
            start          = ($urandom_range(0, 7) == 0);
            do_red         = (nred < 3) && ($urandom_range(0, 9) == 0);
            redirect_valid = do_red;
            redirect_pc    = 8'($urandom_range(0, LAST));
            out_ready      = ($urandom_range(0, 3) != 0);
            if (do_red) begin
               nred++;
               exp_next  = int'(redirect_pc);
               flushed   = 1;
               must_hold = 0;
            end else begin
               flushed   = 0;
               must_hold = out_valid && !out_ready;
               if (out_valid && out_ready) begin
                  if (exp_next == LAST) finished = 1;
                  else exp_next++;
               end
            end
         end
      end
      if (active)
         check(0, "rand_timeout", 64'(id), 64'd0);
      start = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      logic [63:0] act, exp;
      vec_t v;

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h20010003;
      mem[1] = 32'h20020009;
      mem[2] = 32'h00221020;
      mem[3] = 32'h00221824;
      mem[4] = 32'h00222025;

      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      #1;
      act = {14'b0, out_valid, out_instr, out_pc, done, busy};
      check(act == 64'd0, "reset_state", act, 64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check(!busy && !done && imem_addr == 0, "idle_after_reset",
            {54'b0, busy, done, imem_addr}, 64'd0);

      // scenario 1, then 2, 3, 4 each starting from DONE
      add_start(); add_tail(0);
      add_start();
      for (int k = 0; k <= 2; k++) row_pc(k, 1);
      repeat (3) row_pc(2, 0);
      add_tail(3);
      add_start();
      for (int k = 0; k <= 3; k++) row_pc(k, 1);
      add(0, 1, 1, 8'd1, 0, 0, 8'd1, 0);
      add_tail(1);
      add_start();
      for (int k = 0; k <= LAST; k++) row_pc(k, 1);
      row_pc(LAST, 0);
      add(0, 0, 1, 8'd0, 0, 0, 8'd0, 0);
      add_tail(0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         start          = v.start;
         out_ready      = v.ready;
         redirect_valid = v.rv;
         redirect_pc    = v.rpc;
         @(negedge clk);
         act = {14'b0, out_valid, done, imem_addr, 40'b0};
         exp = {14'b0, v.ev, v.edone, v.eaddr, 40'b0};
         if (v.ev) begin
            act[39:0] = {out_pc, out_instr};
            exp[39:0] = {v.epc, mem[v.epc]};
         end
         check(act == exp, $sformatf("vec%0d", i), act, exp);
      end
      start = 1'b0;
      redirect_valid = 1'b0;

      // scenario 5: async reset mid-run, restart, start ignored while busy
      out_ready = 1'b1;
      start = 1'b1;
      wait_neg(1);
      start = 1'b0;
      wait_neg(3);
      expect_word("pre_reset_pc2", 2);
      #2;
      rst_n = 1'b0;
      #1;
      act = {14'b0, out_valid, out_instr, out_pc, done, busy};
      check(act == 64'd0 && imem_addr == 0, "async_reset", act, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      wait_neg(1);
      start = 1'b0;
      check(!out_valid && busy, "restart_bubble",
            {62'b0, out_valid, busy}, 64'b01);
      wait_neg(1);
      expect_word("restart_pc0", 0);
      start = 1'b1;
      wait_neg(1);
      start = 1'b0;
      expect_word("busy_start_pc1", 1);
      wait_neg(1);
      expect_word("busy_start_pc2", 2);
      wait_neg(3);
      check(done && !out_valid, "s5_done", {62'b0, done, out_valid}, 64'b10);

      // redirect in DONE must be ignored
      redirect_valid = 1'b1;
      redirect_pc = 8'd2;
      wait_neg(1);
      redirect_valid = 1'b0;
      check(done && !busy && !out_valid, "redirect_in_done",
            {61'b0, done, busy, out_valid}, 64'b100);

      for (int r = 0; r < 20; r++) rand_run(r);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
